// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and default constants for the stopwatch core.
//   state_e          : top-level operating state of the stopwatch
//   DEF_CLK_HZ       : default system clock frequency
//   DEF_ADJ_HZ       : default adjust step rate
//   DEF_FIELD_MAX    : default largest minutes / seconds value
//   state_is_counting: helper, true when the time fields advance on ticks
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        PAUSED  = 2'd0,
        RUN     = 2'd1,
        ADJUST  = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    localparam int DEF_CLK_HZ    = 100_000_000;
    localparam int DEF_ADJ_HZ    = 2;
    localparam int DEF_FIELD_MAX = 59;

    function automatic logic state_is_counting(input state_e s);
        return (s == RUN);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Free-running enable generator: produces a one-cycle tick every DIV enabled
// cycles. The count is held at zero while clr is high, so the first tick after
// clr drops comes exactly DIV enabled cycles later.
//   clk   : system clock
//   reset : synchronous active-high reset
//   en    : count enable
//   clr   : synchronous clear (priority over en)
//   tick  : high for the cycle in which the counter sits at DIV-1
// -----------------------------------------------------------------------------
module tick_divider
    import stopwatch_pkg::*;
#(
    parameter int DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next-count logic: clear, wrap at DIV-1, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = CNT_ZERO;
        end else if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = CNT_ZERO;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en & ~clr & (cnt_q == CNT_LAST);

endmodule

// File: rtl/stopwatch_core.sv
// -----------------------------------------------------------------------------
// stopwatch_core
// Count-up / count-down stopwatch with pause toggle, per-field adjust, lap
// capture and an expiry flag. All timing is derived from the single clock via
// two tick_divider instances (1 Hz count tick, ADJ_HZ adjust step).
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   pause, lap          : debounced levels, rising edge is the event
//   adjust, select      : adjust mode level / field select (0 min, 1 sec)
//   count_down          : 1 = decrement on each tick
//   minutes, seconds    : current count (registered)
//   running, expired    : state is RUN / EXPIRED (registered)
//   lap_valid           : a lap has been captured since reset
//   lap_min, lap_sec    : captured lap value
// -----------------------------------------------------------------------------
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int  CLK_HZ  = DEF_CLK_HZ,
    parameter int  ADJ_HZ  = DEF_ADJ_HZ,
    parameter int  MIN_MAX = DEF_FIELD_MAX,
    parameter int  SEC_MAX = DEF_FIELD_MAX,
    localparam int MIN_W   = $clog2(MIN_MAX + 1),
    localparam int SEC_W   = $clog2(SEC_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pause,
    input  logic             lap,
    input  logic             adjust,
    input  logic             select,
    input  logic             count_down,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic             running,
    output logic             expired,
    output logic             lap_valid,
    output logic [MIN_W-1:0] lap_min,
    output logic [SEC_W-1:0] lap_sec
);

    localparam int ADJ_DIV = CLK_HZ / ADJ_HZ;

    localparam logic [MIN_W-1:0] MIN_ZERO = {MIN_W{1'b0}};
    localparam logic [MIN_W-1:0] MIN_ONE  = MIN_W'(1);
    localparam logic [MIN_W-1:0] MIN_TOP  = MIN_W'(MIN_MAX);
    localparam logic [SEC_W-1:0] SEC_ZERO = {SEC_W{1'b0}};
    localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);
    localparam logic [SEC_W-1:0] SEC_TOP  = SEC_W'(SEC_MAX);

    state_e           state_q, state_d;
    logic [MIN_W-1:0] minutes_q, minutes_d;
    logic [SEC_W-1:0] seconds_q, seconds_d;
    logic [MIN_W-1:0] lap_min_q, lap_min_d;
    logic [SEC_W-1:0] lap_sec_q, lap_sec_d;
    logic             lap_valid_q, lap_valid_d;
    logic             running_q;
    logic             expired_q;

    // Edge-detect history plus registered events; the registered event is what
    // gives the two-edge pause-to-running latency.
    logic             pause_q, pause_ev_q;
    logic             lap_q, lap_ev_q;

    logic             cnt_tick_s;
    logic             adj_step_s;
    logic             count_zero_s;

    // Prescalers are held cleared outside their own state, which also clears
    // them on entry to that state.
    tick_divider #(.DIV(CLK_HZ)) u_count_div (
        .clk   (clk),
        .reset (reset),
        .en    (state_is_counting(state_q)),
        .clr   (!state_is_counting(state_q)),
        .tick  (cnt_tick_s)
    );

    tick_divider #(.DIV(ADJ_DIV)) u_adjust_div (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == ADJUST),
        .clr   (state_q != ADJUST),
        .tick  (adj_step_s)
    );

    assign count_zero_s = (minutes_q == MIN_ZERO) && (seconds_q == SEC_ZERO);

    // Input edge detection for pause and lap.
    always_ff @(posedge clk) begin
        if (reset) begin
            pause_q    <= 1'b0;
            pause_ev_q <= 1'b0;
            lap_q      <= 1'b0;
            lap_ev_q   <= 1'b0;
        end else begin
            pause_q    <= pause;
            pause_ev_q <= pause & ~pause_q;
            lap_q      <= lap;
            lap_ev_q   <= lap & ~lap_q;
        end
    end

    // Next-state and field arithmetic for the stopwatch FSM.
    always_comb begin
        state_d     = state_q;
        minutes_d   = minutes_q;
        seconds_d   = seconds_q;
        lap_min_d   = lap_min_q;
        lap_sec_d   = lap_sec_q;
        lap_valid_d = lap_valid_q;

        case (state_q)
            PAUSED: begin
                if (adjust) begin
                    state_d = ADJUST;
                end else if (pause_ev_q) begin
                    // Starting a countdown from 00:00 expires immediately.
                    if (count_down && count_zero_s) begin
                        state_d = EXPIRED;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = PAUSED;
                end
            end

            RUN: begin
                // Lap samples the count before this edge's tick is applied.
                if (lap_ev_q) begin
                    lap_min_d   = minutes_q;
                    lap_sec_d   = seconds_q;
                    lap_valid_d = 1'b1;
                end else begin
                    lap_valid_d = lap_valid_q;
                end

                if (cnt_tick_s) begin
                    if (count_down) begin
                        if (seconds_q == SEC_ZERO) begin
                            seconds_d = SEC_TOP;
                            minutes_d = (minutes_q == MIN_ZERO) ? MIN_TOP
                                                                : (minutes_q - MIN_ONE);
                        end else begin
                            seconds_d = seconds_q - SEC_ONE;
                        end
                    end else begin
                        if (seconds_q >= SEC_TOP) begin
                            seconds_d = SEC_ZERO;
                            minutes_d = (minutes_q >= MIN_TOP) ? MIN_ZERO
                                                               : (minutes_q + MIN_ONE);
                        end else begin
                            seconds_d = seconds_q + SEC_ONE;
                        end
                    end
                end else begin
                    seconds_d = seconds_q;
                end

                if (adjust) begin
                    state_d = ADJUST;
                end else if (pause_ev_q) begin
                    state_d = PAUSED;
                end else if (cnt_tick_s && count_down &&
                             (minutes_q == MIN_ZERO) && (seconds_q == SEC_ONE)) begin
                    state_d = EXPIRED;
                end else begin
                    state_d = RUN;
                end
            end

            ADJUST: begin
                // Selected field wraps on its own; no carry between fields.
                if (adj_step_s) begin
                    if (select) begin
                        seconds_d = (seconds_q >= SEC_TOP) ? SEC_ZERO : (seconds_q + SEC_ONE);
                    end else begin
                        minutes_d = (minutes_q >= MIN_TOP) ? MIN_ZERO : (minutes_q + MIN_ONE);
                    end
                end else begin
                    seconds_d = seconds_q;
                end

                if (!adjust) begin
                    state_d = PAUSED;
                end else begin
                    state_d = ADJUST;
                end
            end

            EXPIRED: begin
                if (adjust) begin
                    state_d = ADJUST;
                end else if (pause_ev_q) begin
                    state_d = PAUSED;
                end else begin
                    state_d = EXPIRED;
                end
            end

            default: begin
                state_d = PAUSED;
            end
        endcase
    end

    // State, count, lap and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PAUSED;
            minutes_q   <= MIN_ZERO;
            seconds_q   <= SEC_ZERO;
            lap_min_q   <= MIN_ZERO;
            lap_sec_q   <= SEC_ZERO;
            lap_valid_q <= 1'b0;
            running_q   <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            minutes_q   <= minutes_d;
            seconds_q   <= seconds_d;
            lap_min_q   <= lap_min_d;
            lap_sec_q   <= lap_sec_d;
            lap_valid_q <= lap_valid_d;
            running_q   <= (state_d == RUN);
            expired_q   <= (state_d == EXPIRED);
        end
    end

    assign minutes   = minutes_q;
    assign seconds   = seconds_q;
    assign running   = running_q;
    assign expired   = expired_q;
    assign lap_valid = lap_valid_q;
    assign lap_min   = lap_min_q;
    assign lap_sec   = lap_sec_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_core
// Directed self-checking bench for stopwatch_core with CLK_HZ=8, ADJ_HZ=2,
// MIN_MAX=2, SEC_MAX=3 (a minute is 4 seconds, a tick every 8 cycles, an
// adjust step every 4 cycles). Inputs change and outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       reset, pause, lap, adjust, select, count_down;
    logic [1:0] minutes, seconds, lap_min, lap_sec;
    logic       running, expired, lap_valid;

    int tests = 0;
    int fails = 0;

    stopwatch_core #(.CLK_HZ(8), .ADJ_HZ(2), .MIN_MAX(2), .SEC_MAX(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .pause      (pause),
        .lap        (lap),
        .adjust     (adjust),
        .select     (select),
        .count_down (count_down),
        .minutes    (minutes),
        .seconds    (seconds),
        .running    (running),
        .expired    (expired),
        .lap_valid  (lap_valid),
        .lap_min    (lap_min),
        .lap_sec    (lap_sec)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        pause = 1'b0; lap = 1'b0; adjust = 1'b0; select = 1'b0; count_down = 1'b0;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    // One-cycle pause pulse; returns two edges later when running has changed.
    task automatic pause_pulse();
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        reset = 1'b1; pause = 1'b0; lap = 1'b0; adjust = 1'b0; select = 1'b0; count_down = 1'b0;
        step(3);
        reset = 1'b0;
        tests++;
        if ({minutes, seconds} !== 4'h0) begin
            fails++; $display("FAIL reset_count: got %0d:%0d want 0:0", minutes, seconds);
        end
        tests++;
        if ({running, expired, lap_valid} !== 3'b000) begin
            fails++; $display("FAIL reset_flags: got run=%b exp=%b lapv=%b want 000", running, expired, lap_valid);
        end
        tests++;
        if ({lap_min, lap_sec} !== 4'h0) begin
            fails++; $display("FAIL reset_lap: got %0d:%0d want 0:0", lap_min, lap_sec);
        end
    endtask

    task automatic test_count_up();
        do_reset();
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        tests++;
        if (running !== 1'b0) begin
            fails++; $display("FAIL up_run_edge1: got %b want 0", running);
        end
        step(1);
        tests++;
        if (running !== 1'b1) begin
            fails++; $display("FAIL up_run_edge2: got %b want 1", running);
        end
        step(7);
        tests++;
        if (seconds !== 2'd0) begin
            fails++; $display("FAIL up_before_tick: got %0d want 0", seconds);
        end
        step(1);
        tests++;
        if ({minutes, seconds} !== {2'd0, 2'd1}) begin
            fails++; $display("FAIL up_first_tick: got %0d:%0d want 0:1", minutes, seconds);
        end
        step(40);
        tests++;
        if ({minutes, seconds} !== {2'd1, 2'd2}) begin
            fails++; $display("FAIL up_6_ticks: got %0d:%0d want 1:2", minutes, seconds);
        end
        step(40);
        tests++;
        if ({minutes, seconds} !== {2'd2, 2'd3}) begin
            fails++; $display("FAIL up_max: got %0d:%0d want 2:3", minutes, seconds);
        end
        step(8);
        tests++;
        if ({minutes, seconds, running, expired} !== {2'd0, 2'd0, 1'b1, 1'b0}) begin
            fails++; $display("FAIL up_wrap: got %0d:%0d run=%b exp=%b want 0:0 run=1 exp=0",
                              minutes, seconds, running, expired);
        end
    endtask

    task automatic test_pause_hold();
        do_reset();
        pause = 1'b1;
        step(30);
        tests++;
        if (running !== 1'b1) begin
            fails++; $display("FAIL hold_running: got %b want 1", running);
        end
        tests++;
        if ({minutes, seconds} !== {2'd0, 2'd3}) begin
            fails++; $display("FAIL hold_count: got %0d:%0d want 0:3", minutes, seconds);
        end
        pause = 1'b0;
        step(3);
        tests++;
        if (running !== 1'b1) begin
            fails++; $display("FAIL hold_release: got %b want 1", running);
        end
        pause_pulse();
        tests++;
        if (running !== 1'b0) begin
            fails++; $display("FAIL hold_stop: got %b want 0", running);
        end
    endtask

    task automatic test_expire();
        do_reset();
        adjust = 1'b1; select = 1'b1;
        step(5);
        adjust = 1'b0;
        step(1);
        tests++;
        if ({minutes, seconds, running} !== {2'd0, 2'd1, 1'b0}) begin
            fails++; $display("FAIL exp_preset: got %0d:%0d run=%b want 0:1 run=0", minutes, seconds, running);
        end
        count_down = 1'b1;
        pause_pulse();
        step(7);
        tests++;
        if ({seconds, expired} !== {2'd1, 1'b0}) begin
            fails++; $display("FAIL exp_before: got sec=%0d exp=%b want 1 0", seconds, expired);
        end
        step(1);
        tests++;
        if ({minutes, seconds, running, expired} !== {2'd0, 2'd0, 1'b0, 1'b1}) begin
            fails++; $display("FAIL exp_reach: got %0d:%0d run=%b exp=%b want 0:0 run=0 exp=1",
                              minutes, seconds, running, expired);
        end
        step(16);
        tests++;
        if ({minutes, seconds, expired} !== {2'd0, 2'd0, 1'b1}) begin
            fails++; $display("FAIL exp_hold: got %0d:%0d exp=%b want 0:0 exp=1", minutes, seconds, expired);
        end
        pause_pulse();
        tests++;
        if ({minutes, seconds, running, expired} !== {2'd0, 2'd0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL exp_clear: got %0d:%0d run=%b exp=%b want 0:0 run=0 exp=0",
                              minutes, seconds, running, expired);
        end
        pause_pulse();
        tests++;
        if ({running, expired} !== 2'b01) begin
            fails++; $display("FAIL exp_start_zero: got run=%b exp=%b want run=0 exp=1", running, expired);
        end
        count_down = 1'b0;
    endtask

    task automatic test_adjust();
        do_reset();
        adjust = 1'b1; select = 1'b1;
        step(5);
        select = 1'b0;
        step(3);
        tests++;
        if ({minutes, seconds, running, expired} !== {2'd0, 2'd1, 1'b0, 1'b0}) begin
            fails++; $display("FAIL adj_pre: got %0d:%0d run=%b exp=%b want 0:1 0 0", minutes, seconds, running, expired);
        end
        step(1);
        tests++;
        if ({minutes, seconds} !== {2'd1, 2'd1}) begin
            fails++; $display("FAIL adj_step1: got %0d:%0d want 1:1", minutes, seconds);
        end
        step(4);
        tests++;
        if ({minutes, seconds} !== {2'd2, 2'd1}) begin
            fails++; $display("FAIL adj_step2: got %0d:%0d want 2:1", minutes, seconds);
        end
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        step(3);
        tests++;
        if ({minutes, seconds} !== {2'd0, 2'd1}) begin
            fails++; $display("FAIL adj_wrap: got %0d:%0d want 0:1", minutes, seconds);
        end
        step(4);
        tests++;
        if ({minutes, seconds} !== {2'd1, 2'd1}) begin
            fails++; $display("FAIL adj_step4: got %0d:%0d want 1:1", minutes, seconds);
        end
        adjust = 1'b0;
        step(9);
        tests++;
        if ({minutes, seconds, running} !== {2'd1, 2'd1, 1'b0}) begin
            fails++; $display("FAIL adj_exit: got %0d:%0d run=%b want 1:1 run=0", minutes, seconds, running);
        end
    endtask

    task automatic test_lap();
        do_reset();
        adjust = 1'b1; select = 1'b0;
        step(5);
        select = 1'b1;
        step(8);
        adjust = 1'b0;
        step(1);
        pause_pulse();
        step(6);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        step(1);
        tests++;
        if ({lap_valid, lap_min, lap_sec} !== {1'b1, 2'd1, 2'd2}) begin
            fails++; $display("FAIL lap_capture: got v=%b %0d:%0d want v=1 1:2", lap_valid, lap_min, lap_sec);
        end
        tests++;
        if ({minutes, seconds} !== {2'd1, 2'd3}) begin
            fails++; $display("FAIL lap_tick: got %0d:%0d want 1:3", minutes, seconds);
        end
        pause_pulse();
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        step(2);
        tests++;
        if ({running, lap_valid, lap_min, lap_sec} !== {1'b0, 1'b1, 2'd1, 2'd2}) begin
            fails++; $display("FAIL lap_paused: got run=%b v=%b %0d:%0d want run=0 v=1 1:2",
                              running, lap_valid, lap_min, lap_sec);
        end
    endtask

    task automatic test_down_borrow();
        do_reset();
        adjust = 1'b1; select = 1'b0;
        step(5);
        adjust = 1'b0;
        step(1);
        count_down = 1'b1;
        pause_pulse();
        step(8);
        tests++;
        if ({minutes, seconds} !== {2'd0, 2'd3}) begin
            fails++; $display("FAIL down_borrow: got %0d:%0d want 0:3", minutes, seconds);
        end
        step(8);
        tests++;
        if ({minutes, seconds} !== {2'd0, 2'd2}) begin
            fails++; $display("FAIL down_dec: got %0d:%0d want 0:2", minutes, seconds);
        end
        count_down = 1'b0;
        step(8);
        tests++;
        if ({minutes, seconds} !== {2'd0, 2'd3}) begin
            fails++; $display("FAIL down_to_up: got %0d:%0d want 0:3", minutes, seconds);
        end
        step(8);
        tests++;
        if ({minutes, seconds, running} !== {2'd1, 2'd0, 1'b1}) begin
            fails++; $display("FAIL up_carry: got %0d:%0d run=%b want 1:0 run=1", minutes, seconds, running);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        adjust = 1'b1; select = 1'b0;
        step(9);
        select = 1'b1;
        step(4);
        adjust = 1'b0;
        step(1);
        pause_pulse();
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        step(1);
        tests++;
        if ({running, lap_valid, lap_min, lap_sec} !== {1'b1, 1'b1, 2'd2, 2'd1}) begin
            fails++; $display("FAIL rst_pre: got run=%b v=%b lap %0d:%0d want 1 1 2:1",
                              running, lap_valid, lap_min, lap_sec);
        end
        step(5);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        tests++;
        if ({minutes, seconds, running, expired, lap_valid, lap_min, lap_sec} !== 11'd0) begin
            fails++; $display("FAIL rst_mid: got %0d:%0d run=%b exp=%b v=%b lap %0d:%0d want all 0",
                              minutes, seconds, running, expired, lap_valid, lap_min, lap_sec);
        end
        step(10);
        tests++;
        if ({minutes, seconds, running} !== 5'd0) begin
            fails++; $display("FAIL rst_paused: got %0d:%0d run=%b want 0:0 run=0", minutes, seconds, running);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_pause_hold();
        test_expire();
        test_adjust();
        test_lap();
        test_down_borrow();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 ns");
        $fatal(1);
    end

endmodule
